// File: rtl/tdm_demultiplexer_1_to_4.sv
// Registered 1-to-4 TDM demultiplexer.
// One serial word stream is steered into four single-word lane buffers.
// The lane is chosen by a round-robin slot counter (sequential mode) or by
// an explicit select (addressed mode); start-of-frame re-aligns the counter.
//
// Handshake rule (input side and every lane): a word moves across an
// interface exactly on a rising edge where valid and ready are both high.
// in_ready is combinational from the target lane's buffer state and that
// lane's out_ready, so a lane drained on an edge can be reloaded on the same
// edge and words flow at full rate. valid never depends on ready.
module tdm_demultiplexer_1_to_4 #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [1:0]           in_sel,
  input  logic                 in_sof,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [1:0]           slot
);

  localparam int LANES = 4;

  // Lane buffers and the sequential slot counter.
  logic [WIDTH-1:0] lane_data [LANES];
  logic [LANES-1:0] lane_valid;
  logic [1:0]       slot_q;

  // Per-cycle decisions.
  logic [1:0]       target;
  logic             accept;
  logic [LANES-1:0] load;
  logic [LANES-1:0] drain;
  logic [1:0]       slot_next;

  // Target lane: explicit select wins, then start-of-frame, then the counter.
  always_comb begin
    target = slot_q;
    if (in_mode) begin
      target = in_sel;
    end else if (in_sof) begin
      target = 2'd0;
    end
  end

  // Input readiness and the per-lane load/drain strobes for this cycle.
  always_comb begin
    in_ready = ~lane_valid[target] | out_ready[target];
    accept   = in_valid & in_ready;
    drain    = lane_valid & out_ready;
    load     = '0;
    if (accept) begin
      load[target] = 1'b1;
    end
  end

  // Next slot: only a sequential accept moves the counter, to the lane after
  // the one just written (so a start-of-frame accept leaves it at 1).
  always_comb begin
    slot_next = slot_q;
    if (accept && !in_mode) begin
      slot_next = target + 2'd1;
    end
  end

  // Slot counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= 2'd0;
    end else begin
      slot_q <= slot_next;
    end
  end

  // Lane buffers: a load wins over a drain so a same-edge drain+reload keeps
  // the lane valid with the new word; a plain drain keeps the stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_valid <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (load[i]) begin
          lane_valid[i] <= 1'b1;
          lane_data[i]  <= in_data;
        end else if (drain[i]) begin
          lane_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten the lane buffers onto the output bus, lane i at [i*WIDTH +: WIDTH].
  always_comb begin
    out_data = '0;
    for (int i = 0; i < LANES; i++) begin
      out_data[i*WIDTH +: WIDTH] = lane_data[i];
    end
  end

  assign out_valid = lane_valid;
  assign slot      = slot_q;

endmodule

// File: tb/tb_tdm_demultiplexer_1_to_4.sv
// Bench for tdm_demultiplexer_1_to_4 with WIDTH=4.
module tb_tdm_demultiplexer_1_to_4;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic           in_mode;
  logic [1:0]     in_sel;
  logic           in_sof;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [1:0]     slot;

  int total = 0;
  int bad   = 0;

  // Reference state: lane occupancy, slot counter, and words still owed per lane.
  logic [3:0]   m_valid;
  logic [1:0]   m_slot;
  logic [W+1:0] exp_q[$];   // {lane, data}

  tdm_demultiplexer_1_to_4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_sel    (in_sel),
    .in_sof    (in_sof),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .slot      (slot)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: check at negedge, advance reference at posedge, return at posedge+1.
  task automatic cycle();
    logic [1:0]   t;
    logic         rdy;
    logic         acc;
    int           k;
    logic [W-1:0] got;
    @(negedge clk);
    t   = in_mode ? in_sel : (in_sof ? 2'd0 : m_slot);
    rdy = !m_valid[t] || out_ready[t];
    acc = in_valid && rdy;
    total++;
    if (in_ready !== rdy) begin
      bad++;
      $display("FAIL in_ready got=%b exp=%b t=%0d", in_ready, rdy, t);
    end
    total++;
    if (slot !== m_slot) begin
      bad++;
      $display("FAIL slot got=%0d exp=%0d", slot, m_slot);
    end
    total++;
    if (out_valid !== m_valid) begin
      bad++;
      $display("FAIL out_valid got=%b exp=%b", out_valid, m_valid);
    end
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && out_ready[i]) begin
        k = -1;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (k < 0 && exp_q[j][W+1:W] == i[1:0]) k = j;
        end
        got = out_data[i*W +: W];
        total++;
        if (k < 0) begin
          bad++;
          $display("FAIL drain_unexpected lane=%0d got=%h exp=none", i, got);
        end else begin
          if (got !== exp_q[k][W-1:0]) begin
            bad++;
            $display("FAIL drain_data lane=%0d got=%h exp=%h", i, got, exp_q[k][W-1:0]);
          end
          exp_q.delete(k);
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
    end
    if (acc) begin
      m_valid[t] = 1'b1;
      exp_q.push_back({t, in_data});
      if (!in_mode) m_slot = t + 2'd1;
    end
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (out_valid !== 4'b0 || slot !== 2'd0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_state got v=%b s=%0d d=%h exp v=0 s=0 d=0", out_valid, slot, out_data);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", in_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_sequential();
    logic [1:0] exp_slot;
    out_ready = 4'hf;
    for (int i = 0; i < 5; i++) begin
      exp_slot = i[1:0];
      total++;
      if (slot !== exp_slot || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL seq_slot step=%0d got s=%0d r=%b exp s=%0d r=1", i, slot, in_ready, exp_slot);
      end
      send(4'hA + i[3:0]);
    end
    total++;
    if (slot !== 2'd1 || out_data[3:0] !== 4'hE || out_data[7:4] !== 4'hB || out_data[15:12] !== 4'hD) begin
      bad++;
      $display("FAIL seq_lanes got s=%0d d=%h exp s=1 d=dcbe", slot, out_data);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_stall();
    out_ready = 4'b1101;
    send(4'h5);
    send(4'h6);
    send(4'h7);
    send(4'h8);
    in_data = 4'h9;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (in_ready !== 1'b0 || slot !== 2'd1) begin
        bad++;
        $display("FAIL stall_hold got r=%b s=%0d exp r=0 s=1", in_ready, slot);
      end
    end
    out_ready = 4'hf;
    cycle();
    total++;
    if (slot !== 2'd2 || out_valid[1] !== 1'b1 || out_data[7:4] !== 4'h9) begin
      bad++;
      $display("FAIL stall_release got s=%0d v=%b d=%h exp s=2 v=1 d=9", slot, out_valid[1], out_data[7:4]);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_sof();
    in_sof = 1'b1;
    send(4'h1);
    total++;
    if (slot !== 2'd1 || out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h1) begin
      bad++;
      $display("FAIL sof_accept got s=%0d v=%b d=%h exp s=1 v=1 d=1", slot, out_valid[0], out_data[3:0]);
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if (slot !== 2'd1) begin
      bad++;
      $display("FAIL sof_idle got s=%0d exp s=1", slot);
    end
    in_sof = 1'b0;
  endtask

  task automatic test_addressed();
    in_mode   = 1'b1;
    out_ready = 4'b0111;
    in_sel    = 2'd3;
    send(4'h7);
    in_data = 4'h8;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid[3] !== 1'b1) begin
      bad++;
      $display("FAIL addr_block got r=%b v3=%b exp r=0 v3=1", in_ready, out_valid[3]);
    end
    cycle();
    in_sel = 2'd0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL addr_switch got r=%b exp=1", in_ready);
    end
    cycle();
    total++;
    if (slot !== 2'd1 || out_valid[0] !== 1'b1 || out_data[3:0] !== 4'h8) begin
      bad++;
      $display("FAIL addr_load got s=%0d v0=%b d=%h exp s=1 v0=1 d=8", slot, out_valid[0], out_data[3:0]);
    end
    in_valid  = 1'b0;
    out_ready = 4'hf;
    cycle();
    in_mode = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 4'h0;
    for (int i = 0; i < 4; i++) send(4'hA + i[3:0]);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 4'hf) begin
      bad++;
      $display("FAIL fill_all got=%b exp=1111", out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 4'h0 || slot !== 2'd0 || out_data !== '0) begin
      bad++;
      $display("FAIL async_reset got v=%b s=%0d d=%h exp v=0 s=0 d=0", out_valid, slot, out_data);
    end
    m_valid = 4'h0;
    m_slot  = 2'd0;
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 4'hf;
    cycle();
  endtask

  task automatic test_back_to_back();
    in_mode = 1'b1;
    in_sel  = 2'd2;
    send(4'h3);
    send(4'h4);
    total++;
    if (out_valid[2] !== 1'b1 || out_data[11:8] !== 4'h4) begin
      bad++;
      $display("FAIL b2b_reload got v=%b d=%h exp v=1 d=4", out_valid[2], out_data[11:8]);
    end
    in_valid = 1'b0;
    cycle();
    total++;
    if (out_valid[2] !== 1'b0 || out_data[11:8] !== 4'h4) begin
      bad++;
      $display("FAIL b2b_drain got v=%b d=%h exp v=0 d=4", out_valid[2], out_data[11:8]);
    end
    in_mode = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom_range(0, 15));
      in_mode   = ($urandom_range(0, 3) == 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_sof    = ($urandom_range(0, 7) == 0);
      out_ready = 4'($urandom_range(0, 15));
      cycle();
    end
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_sof    = 1'b0;
    out_ready = 4'hf;
    cycle();
    cycle();
    total++;
    if (exp_q.size() != 0 || out_valid !== 4'h0) begin
      bad++;
      $display("FAIL final_drain got left=%0d v=%b exp left=0 v=0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_sel    = 2'd0;
    in_sof    = 1'b0;
    out_ready = 4'hf;
    m_valid   = 4'h0;
    m_slot    = 2'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_sof();
    test_addressed();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
